csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 213 +++++++++++++++++++++
 tb/tb_csr_file.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file -- machine-mode control and status register file for a small
// RV32 core (single hart, M-mode only).
//
// Reads are purely combinational. Writes, trap entry and mret all take effect
// on the rising clock edge. The 64-bit cycle counter advances on every
// non-reset cycle.
//
// Ports
//   clk         in   1  clock; all state changes on its rising edge
//   rst         in   1  synchronous, active-high reset
//   addr        in  12  CSR address
//   bus         in  32  write data; holds the faulting PC while trap=1
//   csr_out     out 32  value of the addressed CSR (0 if unimplemented)
//   read        in   1  a CSR read access is in progress
//   write       in   1  a CSR write access is in progress
//   write_type  in   2  01 write, 10 set bits, 11 clear bits, 00 no-op
//   trap        in   1  take an exception this cycle
//   trap_cause  in   5  exception code stored into mcause
//   ret         in   1  an mret is executing
//   invalid     out  1  the current access is illegal
// -----------------------------------------------------------------------------
module csr_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic [31:0] bus,
  output logic [31:0] csr_out,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  write_type,
  input  logic        trap,
  input  logic [4:0]  trap_cause,
  input  logic        ret,
  output logic        invalid
);

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Constant register contents
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;  // RV32I
  localparam logic [31:0] MTVEC_VALUE = 32'h0000_0004;  // fixed direct vector
  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;  // MSIE, MTIE, MEIE

  // write_type encodings
  localparam logic [1:0] WT_NOP   = 2'b00;
  localparam logic [1:0] WT_WRITE = 2'b01;
  localparam logic [1:0] WT_SET   = 2'b10;
  localparam logic [1:0] WT_CLEAR = 2'b11;

  // Architectural state
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;

  // Combinational helpers
  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic        w_implemented;
  logic        w_ro_space;
  logic        w_ro_write;
  logic        w_invalid;
  logic [31:0] w_wdata;
  logic        w_wr_en;
  logic [63:0] w_mcycle_inc;
  logic [63:0] w_mcycle_nxt;

  // mstatus view: MPP is hard-wired to M-mode (11), only MIE/MPIE are stored.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  // ---------------------------------------------------------------------------
  // Address decode and read mux
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata       = 32'b0;
    w_implemented = 1'b1;
    case (addr)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MISA:      w_rdata = MISA_VALUE;
      CSR_MIE:       w_rdata = r_mie & MIE_MASK;
      CSR_MTVEC:     w_rdata = MTVEC_VALUE;
      CSR_MSCRATCH:  w_rdata = r_mscratch;
      CSR_MEPC:      w_rdata = r_mepc;
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MTVAL:     w_rdata = r_mtval;
      CSR_MIP:       w_rdata = 32'b0;
      CSR_MCYCLE,
      CSR_CYCLE:     w_rdata = r_mcycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    w_rdata = r_mcycle[63:32];
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID,
      CSR_MHARTID:   w_rdata = 32'b0;
      default:       w_implemented = 1'b0;
    endcase
  end

  assign csr_out = w_rdata;

  // ---------------------------------------------------------------------------
  // Illegal-access detection
  // ---------------------------------------------------------------------------
  // addr[11:10]==11 is the read-only CSR space. A set/clear with a zero mask
  // is the idiom for a plain read (csrrs x, csr, x0) and is therefore legal.
  assign w_ro_space = (addr[11:10] == 2'b11);
  assign w_ro_write = write && w_ro_space &&
                      ((write_type == WT_WRITE) || (write_type[1] && (bus != 32'b0)));
  assign w_invalid  = ((read || write) && !w_implemented) || w_ro_write;
  assign invalid    = w_invalid;

  // ---------------------------------------------------------------------------
  // Write data and enable
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wdata = w_rdata;
    case (write_type)
      WT_WRITE: w_wdata = bus;
      WT_SET:   w_wdata = w_rdata | bus;
      WT_CLEAR: w_wdata = w_rdata & ~bus;
      default:  w_wdata = w_rdata;
    endcase
  end

  // trap outranks ret, which outranks a software write.
  assign w_wr_en = write && !w_invalid && (write_type != WT_NOP) && !trap && !ret;

  // ---------------------------------------------------------------------------
  // Cycle counter: a software write replaces only the half it addresses; the
  // other half still follows the increment (including any carry).
  // ---------------------------------------------------------------------------
  assign w_mcycle_inc = r_mcycle + 64'd1;

  always_comb begin
    w_mcycle_nxt = w_mcycle_inc;
    if (w_wr_en && (addr == CSR_MCYCLE))
      w_mcycle_nxt[31:0] = w_wdata;
    if (w_wr_en && (addr == CSR_MCYCLEH))
      w_mcycle_nxt[63:32] = w_wdata;
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'b0;
      r_mscratch     <= 32'b0;
      r_mepc         <= 32'b0;
      r_mcause       <= 32'b0;
      r_mtval        <= 32'b0;
      r_mcycle       <= 64'b0;
    end else begin
      r_mcycle <= w_mcycle_nxt;

      if (trap) begin
        // Exception entry: save PC and cause, stack the interrupt enable.
        r_mepc         <= {bus[31:2], 2'b00};
        r_mcause       <= {27'b0, trap_cause};
        r_mtval        <= 32'b0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (ret) begin
        // mret: restore the interrupt enable; the controller fetches mepc
        // through csr_out.
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_wr_en) begin
        case (addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wdata[3];
            r_mstatus_mpie <= w_wdata[7];
          end
          CSR_MIE:      r_mie      <= w_wdata & MIE_MASK;
          CSR_MSCRATCH: r_mscratch <= w_wdata;
          CSR_MEPC:     r_mepc     <= {w_wdata[31:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wdata;
          CSR_MTVAL:    r_mtval    <= w_wdata;
          default: ;  // constants, counters (handled above) and read-only CSRs
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file -- self-checking bench for csr_file.
//
// Each vector is one clock cycle of stimulus plus the combinational csr_out /
// invalid values expected during that cycle (i.e. before its rising edge).
// The driver pushes expectations into a scoreboard queue as it drives; a
// negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [31:0] bus;
  logic [31:0] csr_out;
  logic        read;
  logic        write;
  logic [1:0]  write_type;
  logic        trap;
  logic [4:0]  trap_cause;
  logic        ret;
  logic        invalid;

  always #5 clk = ~clk;

  csr_file dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .bus        (bus),
    .csr_out    (csr_out),
    .read       (read),
    .write      (write),
    .write_type (write_type),
    .trap       (trap),
    .trap_cause (trap_cause),
    .ret        (ret),
    .invalid    (invalid)
  );

  typedef struct {
    logic        rst;
    logic [11:0] addr;
    logic [31:0] bus;
    logic        rd;
    logic        wr;
    logic [1:0]  wt;
    logic        tr;
    logic [4:0]  cause;
    logic        rt;
    logic        chk_out;
    logic [31:0] exp_out;
    logic        exp_inv;
  } vec_t;

  typedef struct {
    int          id;
    logic        chk_out;
    logic [31:0] exp_out;
    logic        exp_inv;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [11:0] a, input logic [31:0] b,
                              input logic rd, input logic wr, input logic [1:0] wt,
                              input logic tr, input logic [4:0] c, input logic rt,
                              input logic ck, input logic [31:0] eo, input logic ei);
    vec_t v;
    v.rst = r;   v.addr = a;  v.bus = b;   v.rd = rd;     v.wr = wr;      v.wt = wt;
    v.tr = tr;   v.cause = c; v.rt = rt;   v.chk_out = ck; v.exp_out = eo; v.exp_inv = ei;
    return v;
  endfunction

  function automatic vec_t rdv(input logic [11:0] a, input logic [31:0] eo, input logic ei);
    return mk(1'b0, a, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, eo, ei);
  endfunction

  function automatic vec_t wrv(input logic [11:0] a, input logic [1:0] wt, input logic [31:0] b,
                               input logic ck, input logic [31:0] eo, input logic ei);
    return mk(1'b0, a, b, 1'b0, 1'b1, wt, 1'b0, 5'd0, 1'b0, ck, eo, ei);
  endfunction

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    rst        = v.rst;
    addr       = v.addr;
    bus        = v.bus;
    read       = v.rd;
    write      = v.wr;
    write_type = v.wt;
    trap       = v.tr;
    trap_cause = v.cause;
    ret        = v.rt;
    e.id      = id;
    e.chk_out = v.chk_out;
    e.exp_out = v.exp_out;
    e.exp_inv = v.exp_inv;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares during the low phase of the clock.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_out)
        check($sformatf("v%0d csr_out", e.id), csr_out, e.exp_out);
      check($sformatf("v%0d invalid", e.id), {31'b0, invalid}, {31'b0, e.exp_inv});
    end
  end

  initial begin
    logic [31:0] c0, c1;

    // ---- vector table -------------------------------------------------------
    // reset state
    vecs.push_back(rdv(12'h300, 32'h0000_1800, 1'b0));
    vecs.push_back(rdv(12'h301, 32'h4000_0100, 1'b0));
    vecs.push_back(rdv(12'h305, 32'h0000_0004, 1'b0));
    vecs.push_back(rdv(12'h344, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'hF11, 32'h0000_0000, 1'b0));
    // mscratch write / set / clear / no-op
    vecs.push_back(wrv(12'h340, 2'b01, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'h340, 2'b10, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(wrv(12'h340, 2'b11, 32'hFF00_0000, 1'b1, 32'hDEAD_BEFF, 1'b0));
    vecs.push_back(wrv(12'h340, 2'b00, 32'hFFFF_FFFF, 1'b1, 32'h00AD_BEFF, 1'b0));
    vecs.push_back(rdv(12'h340, 32'h00AD_BEFF, 1'b0));
    // mstatus / mie masks; leave MIE=1, MPIE=0
    vecs.push_back(wrv(12'h300, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0000_1800, 1'b0));
    vecs.push_back(wrv(12'h300, 2'b11, 32'h0000_0080, 1'b1, 32'h0000_1888, 1'b0));
    vecs.push_back(rdv(12'h300, 32'h0000_1808, 1'b0));
    vecs.push_back(wrv(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'h304, 2'b11, 32'h0000_0008, 1'b1, 32'h0000_0888, 1'b0));
    vecs.push_back(rdv(12'h304, 32'h0000_0880, 1'b0));
    // misa ignores writes; mepc low bits forced to zero
    vecs.push_back(wrv(12'h301, 2'b01, 32'h0000_0000, 1'b1, 32'h4000_0100, 1'b0));
    vecs.push_back(rdv(12'h301, 32'h4000_0100, 1'b0));
    vecs.push_back(wrv(12'h341, 2'b01, 32'h0000_0013, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'h343, 2'b01, 32'h0000_0055, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'h342, 2'b01, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0010, 1'b0));
    // trap with MIE=1, PC=0x123, cause 2
    vecs.push_back(mk(1'b0, 12'h343, 32'h0000_0123, 1'b1, 1'b0, 2'b00, 1'b1, 5'd2, 1'b0,
                      1'b1, 32'h0000_0055, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0120, 1'b0));
    vecs.push_back(rdv(12'h342, 32'h0000_0002, 1'b0));
    vecs.push_back(rdv(12'h343, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'h300, 32'h0000_1880, 1'b0));
    // mret with a simultaneous write to mepc: write suppressed
    vecs.push_back(mk(1'b0, 12'h341, 32'h0000_0999, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b1,
                      1'b1, 32'h0000_0120, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0120, 1'b0));
    vecs.push_back(rdv(12'h300, 32'h0000_1888, 1'b0));
    // trap beats simultaneous writes
    vecs.push_back(mk(1'b0, 12'h341, 32'h0000_0040, 1'b0, 1'b1, 2'b01, 1'b1, 5'd3, 1'b0,
                      1'b1, 32'h0000_0120, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0040, 1'b0));
    vecs.push_back(mk(1'b0, 12'h342, 32'h0000_0044, 1'b0, 1'b1, 2'b01, 1'b1, 5'd5, 1'b0,
                      1'b1, 32'h0000_0003, 1'b0));
    vecs.push_back(rdv(12'h342, 32'h0000_0005, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0044, 1'b0));
    vecs.push_back(rdv(12'h300, 32'h0000_1800, 1'b0));
    // illegal accesses
    vecs.push_back(rdv(12'h7C0, 32'h0000_0000, 1'b1));
    vecs.push_back(wrv(12'hF14, 2'b01, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1));
    vecs.push_back(rdv(12'hF14, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'hC00, 2'b10, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0));
    vecs.push_back(wrv(12'hC00, 2'b11, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1));
    vecs.push_back(wrv(12'hF11, 2'b00, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'h000, 32'h0000_0000, 1'b1));
    vecs.push_back(mk(1'b0, 12'h7C0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0,
                      1'b1, 32'h0000_0000, 1'b0));
    // mcycle: low-half carry into high half
    vecs.push_back(wrv(12'hB80, 2'b01, 32'h0000_0000, 1'b0, 32'h0, 1'b0));
    vecs.push_back(wrv(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0));
    vecs.push_back(rdv(12'hB00, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rdv(12'hB80, 32'h0000_0001, 1'b0));
    vecs.push_back(rdv(12'hC00, 32'h0000_0001, 1'b0));
    vecs.push_back(rdv(12'hC80, 32'h0000_0001, 1'b0));
    // mcycle: full 64-bit wrap
    vecs.push_back(wrv(12'hB80, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0));
    vecs.push_back(wrv(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0));
    vecs.push_back(rdv(12'hC80, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(rdv(12'hC80, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'hC00, 32'h0000_0001, 1'b0));
    // reset overrides trap and write
    vecs.push_back(mk(1'b1, 12'h340, 32'h0000_1234, 1'b0, 1'b1, 2'b01, 1'b1, 5'd7, 1'b0,
                      1'b0, 32'h0, 1'b0));
    vecs.push_back(rdv(12'h340, 32'h0000_0000, 1'b0));
    vecs.push_back(rdv(12'hC00, 32'h0000_0001, 1'b0));
    vecs.push_back(rdv(12'h300, 32'h0000_1800, 1'b0));
    vecs.push_back(rdv(12'h341, 32'h0000_0000, 1'b0));
    // invalid is independent of trap; trap still executes
    vecs.push_back(mk(1'b0, 12'h7C0, 32'h0000_0200, 1'b1, 1'b0, 2'b00, 1'b1, 5'd9, 1'b0,
                      1'b1, 32'h0000_0000, 1'b1));
    vecs.push_back(rdv(12'h342, 32'h0000_0009, 1'b0));

    // ---- reset --------------------------------------------------------------
    rst = 1'b1; addr = 12'h0; bus = 32'h0; read = 1'b0; write = 1'b0;
    write_type = 2'b00; trap = 1'b0; trap_cause = 5'd0; ret = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- table --------------------------------------------------------------
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end

    // ---- hand sequence: cycle counter steps by one per clock -----------------
    rst = 1'b0; addr = 12'hC00; bus = 32'h0; read = 1'b1; write = 1'b0;
    write_type = 2'b00; trap = 1'b0; trap_cause = 5'd0; ret = 1'b0;
    @(negedge clk);
    c0 = csr_out;
    @(negedge clk);
    c1 = csr_out;
    check("cycle consecutive step", c1, c0 + 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
